// File: rtl/mole_scheduler.sv
// Whack-a-mole game sequencer: lobby, timed rounds on a 3x3 board, scoring and lives.
// Lit cell comes from a free-running LFSR so player timing perturbs the sequence.
module mole_scheduler #(
    parameter int TICK_DIV  = 500000,
    parameter int GAP_TICKS = 30,
    parameter int UP_TICKS  = 100,
    parameter int ROUNDS    = 30,
    parameter int LIVES     = 3
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       iStart,
    input  logic [8:0] hit,
    output logic [8:0] board_out,
    output logic [2:0] state,
    output logic [7:0] score,
    output logic [1:0] lives,
    output logic [5:0] round,
    output logic [1:0] mif_sel,
    output logic       hit_flag,
    output logic       miss_flag
);

    // state | meaning
    // IDLE  | lobby, waiting for start edge
    // ARM   | clear score/round, load lives
    // GAP   | board dark between rounds
    // UP    | one cell lit, waiting for hit or timeout
    // HIT   | score a correct hit
    // MISS  | charge a life
    // OVER  | game over, results held until start edge
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ARM  = 3'd1,
        S_GAP  = 3'd2,
        S_UP   = 3'd3,
        S_HIT  = 3'd4,
        S_MISS = 3'd5,
        S_OVER = 3'd6
    } state_t;

    localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TMAX = (GAP_TICKS > UP_TICKS) ? GAP_TICKS : UP_TICKS;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [PW-1:0] PRESC_LOAD = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0] GAP_LOAD   = TW'(GAP_TICKS - 1);
    localparam logic [TW-1:0] UP_LOAD    = TW'(UP_TICKS - 1);

    state_t        state_q, state_d;
    logic          istart_q;
    logic [7:0]    lfsr_q;
    logic          lfsr_fb;
    logic [PW-1:0] presc_q, presc_d;
    logic [TW-1:0] ticks_q, ticks_d;
    logic [3:0]    cell_q, cell_d;
    logic [3:0]    cand;
    logic [3:0]    next_cell;
    logic [7:0]    score_q, score_d;
    logic [1:0]    lives_q, lives_d;
    logic [5:0]    round_q, round_d;
    logic          start_edge;
    logic          expired;

    assign start_edge = iStart & ~istart_q;
    assign expired    = (presc_q == '0) && (ticks_q == '0);
    assign lfsr_fb    = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

    always_comb begin
        cand      = (lfsr_q[3:0] < 4'd9) ? lfsr_q[3:0] : (lfsr_q[3:0] - 4'd9);
        next_cell = cand;
        if (cand == cell_q) begin
            next_cell = (cand == 4'd8) ? 4'd0 : (cand + 4'd1);
        end
    end

    always_comb begin
        state_d = state_q;
        cell_d  = cell_q;
        score_d = score_q;
        lives_d = lives_q;
        round_d = round_q;
        case (state_q)
            S_IDLE: begin
                if (start_edge) state_d = S_ARM;
            end
            S_ARM: begin
                score_d = '0;
                lives_d = 2'(LIVES);
                round_d = '0;
                state_d = S_GAP;
            end
            S_GAP: begin
                if (expired) begin
                    cell_d  = next_cell;
                    round_d = round_q + 6'd1;
                    state_d = S_UP;
                end
            end
            S_UP: begin
                // A hit landing on the expiry cycle still counts.
                if (hit[cell_q]) begin
                    score_d = (score_q == 8'hFF) ? score_q : (score_q + 8'd1);
                    state_d = S_HIT;
                end else if (expired) begin
                    lives_d = lives_q - 2'd1;
                    state_d = S_MISS;
                end
            end
            S_HIT: begin
                state_d = (round_q == 6'(ROUNDS)) ? S_OVER : S_GAP;
            end
            S_MISS: begin
                // lives_q already shows the decremented count here.
                state_d = ((lives_q == 2'd0) || (round_q == 6'(ROUNDS))) ? S_OVER : S_GAP;
            end
            S_OVER: begin
                if (start_edge) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        presc_d = presc_q - 1'b1;
        ticks_d = ticks_q;
        if (presc_q == '0) begin
            presc_d = PRESC_LOAD;
            if (ticks_q != '0) ticks_d = ticks_q - 1'b1;
        end
        if (state_d != state_q) begin
            if (state_d == S_GAP) begin
                presc_d = PRESC_LOAD;
                ticks_d = GAP_LOAD;
            end else if (state_d == S_UP) begin
                presc_d = PRESC_LOAD;
                ticks_d = UP_LOAD;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            istart_q <= 1'b1;
            lfsr_q   <= 8'hA5;
            presc_q  <= '0;
            ticks_q  <= '0;
            cell_q   <= '0;
            score_q  <= '0;
            lives_q  <= '0;
            round_q  <= '0;
        end else begin
            state_q  <= state_d;
            istart_q <= iStart;
            lfsr_q   <= {lfsr_q[6:0], lfsr_fb};
            presc_q  <= presc_d;
            ticks_q  <= ticks_d;
            cell_q   <= cell_d;
            score_q  <= score_d;
            lives_q  <= lives_d;
            round_q  <= round_d;
        end
    end

    assign board_out = (state_q == S_UP) ? (9'd1 << cell_q) : 9'd0;
    assign state     = state_q;
    assign score     = score_q;
    assign lives     = lives_q;
    assign round     = round_q;
    assign hit_flag  = (state_q == S_HIT);
    assign miss_flag = (state_q == S_MISS);
    assign mif_sel   = (state_q == S_IDLE) ? 2'd0 :
                       (state_q == S_OVER) ? 2'd2 : 2'd1;

endmodule

// File: tb/tb_mole_scheduler.sv
// Bench for mole_scheduler: scripted games with a flag scoreboard and an LFSR cell model.
module tb_mole_scheduler;

    localparam int TICK_DIV  = 4;
    localparam int GAP_TICKS = 2;
    localparam int UP_TICKS  = 5;
    localparam int ROUNDS    = 4;
    localparam int LIVES     = 3;
    localparam int GAP_CYC   = GAP_TICKS * TICK_DIV;
    localparam int UP_CYC    = UP_TICKS * TICK_DIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b1;
    logic [8:0] hit = '0;
    logic [8:0] board_out;
    logic [2:0] state;
    logic [7:0] score;
    logic [1:0] lives;
    logic [5:0] round;
    logic [1:0] mif_sel;
    logic       hit_flag;
    logic       miss_flag;

    mole_scheduler #(
        .TICK_DIV (TICK_DIV),
        .GAP_TICKS(GAP_TICKS),
        .UP_TICKS (UP_TICKS),
        .ROUNDS   (ROUNDS),
        .LIVES    (LIVES)
    ) dut (
        .CLOCK_50 (clk),
        .reset    (rst_n),
        .iStart   (start),
        .hit      (hit),
        .board_out(board_out),
        .state    (state),
        .score    (score),
        .lives    (lives),
        .round    (round),
        .mif_sel  (mif_sel),
        .hit_flag (hit_flag),
        .miss_flag(miss_flag)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    typedef struct {
        bit is_hit;
        int score;
        int lives;
        int round;
    } ev_t;
    ev_t sb_q[$];

    always @(negedge clk) begin : monitor
        ev_t e;
        if (rst_n && (hit_flag || miss_flag)) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_flag", 1, 0);
            end else begin
                e = sb_q.pop_front();
                chk("sb_hit_flag", int'(hit_flag), int'(e.is_hit));
                chk("sb_miss_flag", int'(miss_flag), int'(!e.is_hit));
                chk("sb_score", int'(score), e.score);
                chk("sb_lives", int'(lives), e.lives);
                chk("sb_round", int'(round), e.round);
            end
        end
    end

    // Reference LFSR; m_lfsr_prev is the value the DUT saw on the last edge.
    logic [7:0] m_lfsr, m_lfsr_prev;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_lfsr      <= 8'hA5;
            m_lfsr_prev <= 8'hA5;
        end else begin
            m_lfsr      <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
            m_lfsr_prev <= m_lfsr;
        end
    end

    int m_prev_cell = 0;
    int exp_score = 0;
    int exp_lives = 0;
    int exp_round = 0;

    function automatic int exp_cell(input logic [7:0] l, input int prev);
        int cand;
        cand = int'(l[3:0]);
        if (cand >= 9) cand -= 9;
        if (cand == prev) cand = (cand + 1) % 9;
        return cand;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_leave(input int st, output int n);
        n = 0;
        while (int'(state) == st && n < 500) begin
            step();
            n++;
        end
    endtask

    task automatic start_press();
        start = 1'b0;
        step();
        start = 1'b1;
        step();
    endtask

    task automatic begin_game();
        start_press();
        chk("arm_state", int'(state), 1);
        step();
        exp_score = 0;
        exp_lives = LIVES;
        exp_round = 0;
        chk("gap_entry_state", int'(state), 2);
        chk("gap_entry_lives", int'(lives), LIVES);
        chk("gap_entry_score", int'(score), 0);
        chk("gap_entry_round", int'(round), 0);
        chk("gap_entry_mif", int'(mif_sel), 1);
    endtask

    // Entered on the first GAP cycle; returns on the cycle after HIT/MISS.
    task automatic play_round(input bit do_hit, input int hit_cyc, input bit wrong_first);
        int n;
        int c;
        chk("gap_board", int'(board_out), 0);
        wait_leave(2, n);
        chk("gap_len", n, GAP_CYC);
        chk("up_state", int'(state), 3);
        exp_round++;
        c = exp_cell(m_lfsr_prev, m_prev_cell);
        chk("up_board", int'(board_out), 1 << c);
        chk("up_onehot", $countones(board_out), 1);
        chk("cell_differs", int'(board_out == (9'd1 << m_prev_cell)), 0);
        chk("up_round", int'(round), exp_round);
        chk("up_lives", int'(lives), exp_lives);
        chk("up_mif", int'(mif_sel), 1);
        m_prev_cell = c;
        if (do_hit) begin
            n = 1;
            if (wrong_first) begin
                hit = 9'd1 << ((c + 1) % 9);
                step();
                hit = '0;
                n++;
                chk("wrong_hit_state", int'(state), 3);
                chk("wrong_hit_score", int'(score), exp_score);
                chk("wrong_hit_lives", int'(lives), exp_lives);
            end
            while (n < hit_cyc) begin
                step();
                n++;
            end
            chk("pre_hit_state", int'(state), 3);
            exp_score++;
            sb_q.push_back('{1'b1, exp_score, exp_lives, exp_round});
            hit = 9'd1 << c;
            step();
            hit = '0;
            chk("hit_state", int'(state), 4);
            chk("hit_board", int'(board_out), 0);
            chk("hit_score", int'(score), exp_score);
            chk("hit_flag", int'(hit_flag), 1);
            step();
            chk("hit_flag_clear", int'(hit_flag), 0);
            chk("after_hit_state", int'(state), (exp_round == ROUNDS) ? 6 : 2);
        end else begin
            exp_lives--;
            sb_q.push_back('{1'b0, exp_score, exp_lives, exp_round});
            wait_leave(3, n);
            chk("up_len", n, UP_CYC);
            chk("miss_state", int'(state), 5);
            chk("miss_flag", int'(miss_flag), 1);
            chk("miss_lives", int'(lives), exp_lives);
            step();
            chk("miss_flag_clear", int'(miss_flag), 0);
            chk("after_miss_state", int'(state),
                (exp_lives == 0 || exp_round == ROUNDS) ? 6 : 2);
        end
    endtask

    initial begin
        int n;
        repeat (3) step();
        chk("rst_state", int'(state), 0);
        chk("rst_board", int'(board_out), 0);
        chk("rst_mif", int'(mif_sel), 0);
        chk("rst_score", int'(score), 0);
        chk("rst_lives", int'(lives), 0);
        chk("rst_round", int'(round), 0);
        chk("rst_flags", int'({hit_flag, miss_flag}), 0);
        rst_n = 1'b1;
        repeat (4) step();
        chk("held_start_idle", int'(state), 0);
        chk("held_start_mif", int'(mif_sel), 0);

        // Game 1: all hits, wrong-cell hit first, round 2 hit on the expiry cycle.
        begin_game();
        play_round(1'b1, 2, 1'b1);
        play_round(1'b1, UP_CYC, 1'b0);
        play_round(1'b1, 7, 1'b0);
        play_round(1'b1, 11, 1'b0);
        chk("g1_over_mif", int'(mif_sel), 2);
        chk("g1_over_board", int'(board_out), 0);
        chk("g1_final_score", int'(score), 4);
        chk("g1_final_round", int'(round), 4);
        chk("g1_final_lives", int'(lives), 3);
        repeat (3) step();
        chk("g1_over_hold_state", int'(state), 6);
        chk("g1_over_hold_score", int'(score), 4);
        start_press();
        chk("g1_to_idle", int'(state), 0);
        chk("g1_idle_mif", int'(mif_sel), 0);

        // Game 2: no hits, lives run out on round 3.
        begin_game();
        play_round(1'b0, 0, 1'b0);
        play_round(1'b0, 0, 1'b0);
        play_round(1'b0, 0, 1'b0);
        chk("g2_over_mif", int'(mif_sel), 2);
        chk("g2_over_round", int'(round), 3);
        chk("g2_over_lives", int'(lives), 0);
        chk("g2_over_score", int'(score), 0);
        start_press();
        chk("g2_to_idle", int'(state), 0);

        // Game 3: score once, then reset during the next UP window.
        begin_game();
        play_round(1'b1, 4, 1'b0);
        wait_leave(2, n);
        chk("g3_gap_len", n, GAP_CYC);
        chk("g3_up_state", int'(state), 3);
        chk("g3_score_before_rst", int'(score), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_state", int'(state), 0);
        chk("midrst_board", int'(board_out), 0);
        chk("midrst_score", int'(score), 0);
        chk("midrst_mif", int'(mif_sel), 0);
        step();
        chk("sb_empty", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mole_scheduler.md
# mole_scheduler

Game-sequencing controller for the 3×3 whack-a-mole board. It waits in the lobby for a start press and then runs a fixed number of rounds. Each round lights one pseudo-random cell for a timed window, scores correct hits and charges lives for misses. It drives the datapath's `board_out` and selects the background image (lobby, game or game-over).

## Interface
Parameters:
- `TICK_DIV`, default 500000: clock cycles per game tick (10 ms at 50 MHz).
- `GAP_TICKS`, default 30: ticks the board stays dark between rounds.
- `UP_TICKS`, default 100: ticks a cell stays lit.
- `ROUNDS`, default 30: rounds per game, range 1..63.
- `LIVES`, default 3: starting lives, range 1..3.

Ports:
- `CLOCK_50`, in, 1: system clock. One clock domain; all state updates on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `iStart`, in, 1: start button, active-high, already synchronized. Acted on at its rising edge only.
- `hit`, in, 9: per-cell hit strobes, already synchronized. Bit i corresponds to cell i.
- `board_out`, out, 9: one-hot lit cell, or 0.
- `state`, out, 3: current FSM state encoding.
- `score`, out, 8: correct hits this game, saturating at 255.
- `lives`, out, 2: remaining lives.
- `round`, out, 6: number of the current or last round.
- `mif_sel`, out, 2: background image select. 0 = lobby, 1 = game, 2 = game over.
- `hit_flag`, out, 1: one-cycle pulse when a hit is scored.
- `miss_flag`, out, 1: one-cycle pulse when a life is lost.

## Operation
- FSM states and encodings:
  - IDLE = 0, ARM = 1, GAP = 2, UP = 3, HIT = 4, MISS = 5, OVER = 6.
- Start edge detection:
  - `start_edge` = `iStart & ~iStart_d`, where `iStart_d` is a register.
  - `iStart_d` resets to 1, so a button held through reset release does not start a game.
- IDLE:
  - `board_out` = 0, `mif_sel` = 0.
  - `start_edge` moves the FSM to ARM.
- ARM (one cycle):
  - Sets `score` = 0, `lives` = `LIVES`, `round` = 0, then moves to GAP.
- GAP:
  - `board_out` = 0, `mif_sel` = 1.
  - On expiry of `GAP_TICKS` ticks: latch the new cell, increment `round`, move to UP.
- UP:
  - `board_out` = `1 << cell`.
  - `hit[cell]` = 1 moves the FSM to HIT.
  - Expiry of `UP_TICKS` ticks with no hit moves the FSM to MISS.
  - Hits on other cells are ignored: no penalty and no state change.
- HIT (one cycle):
  - `score` increments, saturating at 255. `hit_flag` = 1.
  - Moves to OVER if `round` == `ROUNDS`, otherwise to GAP.
- MISS (one cycle):
  - `lives` decrements. `miss_flag` = 1.
  - Moves to OVER if `lives` was 1 or `round` == `ROUNDS`, otherwise to GAP.
- OVER:
  - `board_out` = 0, `mif_sel` = 2.
  - `score`, `lives` and `round` are held.
  - `start_edge` moves the FSM to IDLE.
- `start_edge` is ignored in every state except IDLE and OVER.
- Cell selection:
  - An 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) is seeded with 8'hA5 at reset and steps every cycle, so player timing varies the sequence.
  - Let `v` = `lfsr[3:0]`. Candidate cell = `v` if `v` < 9, otherwise `v` − 9.
  - If the candidate equals the previous cell, use (candidate + 1) mod 9. Consecutive cells never repeat.
  - The previous-cell register resets to 0.
- Tick generator:
  - A prescaler counts 0..`TICK_DIV`−1 and produces a tick on the terminal count.
  - Prescaler and tick counter both clear on entry to GAP and to UP, so window lengths are exact.

## Timing
- Reset (asynchronous, while `reset` = 0):
  - State = IDLE.
  - All outputs are 0 except `mif_sel` = 0 and `state` = 0.
  - `lives` = 0 and `round` = 0 until ARM.
- Reset asserted mid-game aborts immediately to IDLE. No score is retained.
- All outputs are registered or decoded from registers only. There are no combinational paths from `hit` or `iStart` to any output.
- Start latency:
  - `start_edge` sampled at cycle n → ARM at n+1 → GAP at n+2.
- GAP duration:
  - Exactly `GAP_TICKS`×`TICK_DIV` cycles, then UP.
  - `board_out` is lit in the first UP cycle.
- UP duration:
  - Exactly `UP_TICKS`×`TICK_DIV` cycles if no hit.
  - A hit sampled at UP cycle k gives HIT at k+1 with `board_out` = 0.
- Simultaneous `hit[cell]` and UP expiry in the same cycle: the hit wins and the FSM goes to HIT.
- `hit_flag` and `miss_flag` are high exactly one cycle, concurrent with HIT or MISS.

## Test plan
Bench parameters: `TICK_DIV`=4, `GAP_TICKS`=2, `UP_TICKS`=5, `ROUNDS`=4, `LIVES`=3.
- Reset behaviour: hold `reset`=0 with `iStart`=1, then release while `iStart` stays 1 → `state`=0, `mif_sel`=0, `board_out`=0, and the FSM stays in IDLE.
- Start sequence: drop then raise `iStart` → ARM one cycle later, then GAP. After exactly 8 GAP cycles the FSM is in UP with `popcount(board_out)`=1, `round`=1, `lives`=3, `mif_sel`=1.
- Hit scoring, part 1: assert a wrong-cell `hit` in UP → no change.
- Hit scoring, part 2: assert `hit[cell]` → next cycle `state`=4, `score`=1, one-cycle `hit_flag`, `board_out`=0.
- Misses: never hit → each UP lasts exactly 20 cycles and is followed by MISS. `lives` steps 3→2→1→0; after the third miss the FSM enters OVER with `mif_sel`=2 and `round`=3.
- Full game and tie-break: hit all 4 rounds, with round 2's hit coincident with UP expiry → HIT taken, final `score`=4, OVER. Successive lit cells always differ. Then a start edge returns the FSM to IDLE.
- Reset mid-game: assert `reset`=0 during UP → immediately `state`=0, `board_out`=0, `score`=0.
